// File: rtl/serial_adder_arbiter.sv
// Round-robin front end sharing one bit-serial full-adder cell
// between NREQ requesters; results leave on a valid/ready port.
module serial_adder_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]          rsp_sum,
    output logic                      rsp_carry,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic [IDW:0]     cand;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_next;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             accept;
    logic             last_step;
    logic             s_bit;
    logic             c_next;

    // cand spans two laps of the ring, so one subtract wraps it back
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, last_grant} + (IDW+1)'(k + 1);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                op_a = req_a[i*WIDTH +: WIDTH];
                op_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !RST && gnt_found) begin
            req_ready = NREQ'(1) << gnt_idx;
        end
    end

    assign accept    = |req_ready;
    assign last_step = (state == RUN) && (cnt_q == CW'(WIDTH - 1));
    assign s_bit     = a_q[0] ^ b_q[0] ^ c_q;
    assign c_next    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    assign sum_next  = {s_bit, sum_q[WIDTH-1:1]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = RUN;
            RUN:  if (last_step) state_n = DONE;
            DONE: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // sum shifts in at the MSB so bit k lands at position k after WIDTH steps
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= IDW'(NREQ - 1);
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            c_q        <= 1'b0;
            cnt_q      <= '0;
            rsp_sum    <= '0;
            rsp_carry  <= 1'b0;
            rsp_id     <= '0;
        end else if (accept) begin
            a_q        <= op_a;
            b_q        <= op_b;
            id_q       <= gnt_idx;
            c_q        <= 1'b0;
            cnt_q      <= '0;
            last_grant <= gnt_idx;
        end else if (state == RUN) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            sum_q <= sum_next;
            c_q   <= c_next;
            cnt_q <= cnt_q + 1'b1;
            if (last_step) begin
                rsp_sum   <= sum_next;
                rsp_carry <= c_next;
                rsp_id    <= id_q;
            end
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: doc/serial_adder_arbiter.md
# serial_adder_arbiter

Bit-serial addition engine that shares one full-adder cell between NREQ requesters. It sits between the requesting logic and a single adder datapath. Each cycle it arbitrates round-robin, accepts one operand pair, and sequences the 1-bit adder cell LSB-first over WIDTH cycles. It returns the sum and carry-out on a valid/ready response port.

## Interface
- WIDTH, 32: operand and sum width in bits; must be ≥ 2.
- NREQ, 2: number of requesters; must be ≥ 2.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  requester i has an operand pair on req_a/req_b slice i.
- req_ready  out  NREQ  one-hot grant/accept; bit i high means the pair from requester i is taken this cycle.
- req_a  in  NREQ*WIDTH  operand A; slice i is [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- rsp_valid  out  1  a result is available.
- rsp_ready  in  1  the consumer takes the result.
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the result.
- rsp_sum  out  WIDTH  (A + B) mod 2^WIDTH.
- rsp_carry  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant the first requester with req_valid high, searching from (last_grant+1) mod NREQ upward and wrapping.
  - req_ready is combinational and is high only for that requester. It is all-zero when no req_valid is high, and all-zero in RUN and DONE.
  - On the accept edge: latch A, B and id; clear carry and bit counter; set last_grant = id; go to RUN.
- RUN: one bit per cycle.
  - s = a0 ^ b0 ^ c; c_next = majority(a0, b0, c).
  - A and B shift right by 1.
  - s enters the sum register at the MSB while the register shifts right. After WIDTH steps, bit k of the sum is at position k.
  - Bit counter increments. On the step with counter == WIDTH-1, register the final carry in rsp_carry and go to DONE.
- DONE:
  - rsp_valid is high. rsp_id, rsp_sum and rsp_carry are stable until the handshake.
  - On rsp_valid & rsp_ready, go to IDLE.
  - rsp_sum, rsp_carry and rsp_id keep their last values after the handshake. Only rsp_valid drops.
- Arithmetic: unsigned modulo 2^WIDTH; the carry is exported, not dropped. There is no signed overflow flag.
- Requester protocol:
  - A requester holds req_valid and its operands stable until it sees req_ready.
  - req_ready may depend on req_valid. req_valid must not depend on req_ready.
  - A requester that drops req_valid before it is granted is simply skipped.
- Reset:
  - state = IDLE, rsp_valid = 0, rsp_sum = 0, rsp_carry = 0, rsp_id = 0, busy = 0.
  - last_grant = NREQ-1, so requester 0 wins first.
  - req_ready is forced to all-zero while RST is high.
- Reset mid-operation: the work in progress is discarded. No response is ever produced for it, and the requester is not notified.

## Timing
- Accept cycle = cycle 0, meaning the cycle in which req_valid & req_ready is high.
- RUN occupies cycles 1..WIDTH.
- rsp_valid first goes high in cycle WIDTH+1.
- Earliest next accept:
  - cycle WIDTH+2, if rsp_ready is high in cycle WIDTH+1;
  - otherwise, the cycle after the response handshake.
- Peak throughput: one addition per WIDTH+2 cycles.
- Simultaneous requests: exactly one is granted per IDLE cycle. Losers keep req_valid and are served in round-robin order. Under continuous load, no requester waits for more than NREQ-1 other grants.
- A response handshake and a new grant never occur in the same cycle. The new grant happens in IDLE, one cycle after DONE exits.
- busy rises in cycle 1 and falls in the cycle after the response handshake.

## Test plan
- Single request, WIDTH=32, NREQ=2:
  - Stimulus: req0 with A=0x00000001, B=0x00000001, rsp_ready held high.
  - Required: req_ready=01 in cycle 0; rsp_valid high in cycle 33 with rsp_sum=0x00000002, rsp_carry=0, rsp_id=0; next accept possible in cycle 34.
- Wrap-around:
  - Stimulus: A=0xFFFFFFFF, B=0x00000001.
  - Required: rsp_sum=0x00000000, rsp_carry=1.
  - Also: A=0x80000000, B=0x80000000 → rsp_sum=0, rsp_carry=1. A=0x12345678, B=0x0FEDCBA8 → rsp_sum=0x22222220, rsp_carry=0.
- Contention:
  - Stimulus: req_valid=11 held continuously from the cycle after reset.
  - Required: grants go 0,1,0,1; rsp_id sequence is 0,1,0,1; each result matches its own operands.
- Backpressure:
  - Stimulus: rsp_ready held low for 10 cycles after rsp_valid rises.
  - Required: rsp_valid, rsp_id and rsp_sum stay constant; req_ready=00 throughout; release of rsp_ready → handshake, then a grant in the following cycle.
- Reset mid-RUN:
  - Stimulus: assert RST for one cycle in cycle 10 of an addition.
  - Required: in the next cycle state is IDLE, rsp_valid=0, busy=0; no response is ever emitted for that addition; with req_valid=11, requester 0 is granted first.
- Skip idle requester:
  - Stimulus: only req1 is valid after last_grant=1.
  - Required: req1 is granted immediately (req_ready=10) and is not blocked waiting for req0.
